// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: bus widths, the opcode
// field position inside a command word, the HALT opcode, the fetch FSM state
// type and the prefetch buffer entry layout.
package fetch_pkg;

  localparam int ADDR_W  = 8;   // instruction pointer / program memory address width
  localparam int INSTR_W = 24;  // command word width
  localparam int OPC_HI  = 23;  // opcode field [23:18]
  localparam int OPC_LO  = 18;

  localparam logic [OPC_HI-OPC_LO:0] OPC_HALT = 6'b111111;

  typedef enum logic [1:0] {
    RUN,       // issuing fetch requests
    STOPPING,  // HALT buffered, no new requests
    HALTED     // HALT consumed by the decoder
  } fetchState_e;

  // One prefetch buffer entry: the word and the address it was fetched from.
  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] instr;
  } fetchEntry_t;

  function automatic logic isHalt(input logic [INSTR_W-1:0] instr);
    return instr[OPC_HI:OPC_LO] == OPC_HALT;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch stage bus bundle.
//   mem_*       : program memory read port (request pulse, response pulse)
//   cmd_*       : valid/ready command stream towards the decoder
//   jump_*      : redirect request from the decoder
//   halted      : fetch stopped after a consumed HALT
// Modport master is the fetch stage, slave is its environment.
interface instruction_fetch_if;
  import fetch_pkg::*;

  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_rvalid;
  logic [INSTR_W-1:0] mem_rdata;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [INSTR_W-1:0] cmd_out;
  logic [ADDR_W-1:0]  cmd_addr;
  logic               jump_en;
  logic [ADDR_W-1:0]  jump_target;
  logic               halted;

  modport master (
    output mem_req, mem_addr, cmd_valid, cmd_out, cmd_addr, halted,
    input  mem_rvalid, mem_rdata, cmd_ready, jump_en, jump_target
  );

  modport slave (
    input  mem_req, mem_addr, cmd_valid, cmd_out, cmd_addr, halted,
    output mem_rvalid, mem_rdata, cmd_ready, jump_en, jump_target
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH-entry FIFO of {addr, instr} entries.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   push/pushData: write an entry at the tail
//   pop          : drop the head entry (caller guarantees not empty)
//   flush        : synchronous clear of all entries
//   headData     : current head entry (meaningless while empty)
//   count/full/empty : occupancy
// DEPTH must be a power of two so the pointers wrap by overflow.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetchEntry_t                  pushData,
  output fetchEntry_t                  headData,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  fetchEntry_t      storage [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;

  // NOTE: storage is deliberately left without reset; an entry is only ever
  // read after it has been written, and the top masks the head while empty.
  always_ff @(posedge clock) begin
    if (push) begin
      storage[wrPtr] <= pushData;
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // sees the pre-edge value of every other register.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign headData = storage[rdPtr];
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch front end. Walks pc through program memory with at most
// one read outstanding, buffers returned words in a prefetch FIFO and offers
// them with their addresses to the decoder over valid/ready. Decoder jumps
// flush the buffer and redirect fetch; a HALT word stops fetching once it
// has been fetched and halts the stage once the decoder consumes it.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   fetchBus     : memory read port, command stream, jump input, halted
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
  input  logic                 clock,
  input  logic                 reset,
  instruction_fetch_if.master  fetchBus
);

  localparam int CNT_W = $clog2(DEPTH+1);

  fetchState_e       state;
  fetchState_e       stateNext;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] reqAddr;      // address of the outstanding request
  logic              outstanding;
  logic              discard;      // outstanding response belongs to a flushed stream

  logic              rspFire;
  logic              pushEn;
  logic              popEn;
  logic              rspIsHalt;
  logic              fits;
  logic              issue;
  fetchEntry_t       pushData;
  fetchEntry_t       headData;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;

  // A response only counts when a request is actually outstanding.
  assign rspFire   = fetchBus.mem_rvalid && outstanding;
  assign pushEn    = rspFire && !discard && !fetchBus.jump_en;
  assign popEn     = !empty && fetchBus.cmd_ready && !fetchBus.jump_en;
  assign rspIsHalt = isHalt(fetchBus.mem_rdata);
  assign pushData  = '{addr: reqAddr, instr: fetchBus.mem_rdata};

  // Room check on the occupancy this cycle's push/pop will leave behind,
  // so a new request always has a slot reserved for its response.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    fits = !full;
    if (pushEn && !popEn)      fits = (count < CNT_W'(DEPTH - 1));
    else if (popEn && !pushEn) fits = 1'b1;
  end

  // A HALT arriving now stops the request that would otherwise follow it,
  // so no word past the HALT is ever fetched.
  assign issue = !reset && (state == RUN) && !fetchBus.jump_en && !discard &&
                 (!outstanding || rspFire) && fits && !(pushEn && rspIsHalt);

  always_comb begin
    stateNext       = state;
    fetchBus.halted = (state == HALTED);
    if (fetchBus.jump_en) begin
      stateNext = RUN;
    end else begin
      case (state)
        RUN:      if (pushEn && rspIsHalt) stateNext = STOPPING;
        STOPPING: if (popEn && isHalt(headData.instr)) stateNext = HALTED;
        default:  stateNext = state;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= RUN;
    else       state <= stateNext;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc          <= RESET_PC;
      reqAddr     <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
    end else if (fetchBus.jump_en) begin
      pc <= fetchBus.jump_target;
      // A response landing in the jump cycle is simply dropped; one still in
      // flight must be swallowed when it arrives.
      if (outstanding && !fetchBus.mem_rvalid) begin
        discard <= 1'b1;
      end else begin
        outstanding <= 1'b0;
        discard     <= 1'b0;
      end
    end else begin
      if (issue) begin
        pc      <= pc + 1'b1;
        reqAddr <= pc;
      end
      if (issue)        outstanding <= 1'b1;
      else if (rspFire) outstanding <= 1'b0;
      if (rspFire) discard <= 1'b0;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (pushEn),
    .pop      (popEn),
    .flush    (fetchBus.jump_en),
    .pushData (pushData),
    .headData (headData),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  assign fetchBus.mem_req   = issue;
  assign fetchBus.mem_addr  = pc;
  assign fetchBus.cmd_valid = !empty;
  assign fetchBus.cmd_out   = empty ? '0 : headData.instr;
  assign fetchBus.cmd_addr  = empty ? '0 : headData.addr;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch. Inputs change on the falling edge,
// outputs are sampled 2 time units later. A program memory model with
// programmable latency answers the main instance; a second instance with
// RESET_PC = 8'hFE sits behind a fixed one-cycle memory.
module tb_instruction_fetch;
  import fetch_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  instruction_fetch_if bus ();
  instruction_fetch_if feBus ();

  instruction_fetch #(.DEPTH(2), .RESET_PC(8'h00)) dut (
    .clock(clock), .reset(reset), .fetchBus(bus)
  );

  instruction_fetch #(.DEPTH(2), .RESET_PC(8'hFE)) dutFe (
    .clock(clock), .reset(reset), .fetchBus(feBus)
  );

  logic [23:0] prog [256];
  int nChecks = 0;
  int nPass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- program memory model (main instance) ----------------
  typedef struct packed {
    logic [7:0] addr;
    int         due;
  } pend_t;

  pend_t pendQ [$];
  int    cyc      = 0;
  int    memLat   = 1;
  int    latReq   = 1;
  int    protoErr = 0;
  logic  ghost    = 1'b0;

  always @(negedge clock) begin
    cyc++;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    if (ghost) begin
      // Late answer to a request killed by reset.
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 24'hFC0000;
      ghost = 1'b0;
    end else if (pendQ.size() > 0 && pendQ[0].due == cyc) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = prog[pendQ[0].addr];
      void'(pendQ.pop_front());
    end
    #2;
    if (reset === 1'b1) begin
      if (pendQ.size() > 0) ghost = 1'b1;
      pendQ.delete();
    end else if (bus.mem_req === 1'b1) begin
      if (pendQ.size() > 0) protoErr++;
      pendQ.push_back('{addr: bus.mem_addr, due: cyc + memLat});
    end
  end

  // ---------------- one-cycle memory (RESET_PC = 8'hFE instance) ----------------
  logic       fePend     = 1'b0;
  logic [7:0] fePendAddr = '0;

  always @(negedge clock) begin
    feBus.mem_rvalid = fePend;
    feBus.mem_rdata  = {16'h0400, fePendAddr};
    #2;
    fePend     = (feBus.mem_req === 1'b1);
    fePendAddr = feBus.mem_addr;
  end

  // ---------------- stimulus helpers ----------------
  logic       sbOn    = 1'b0;
  logic [7:0] expAddr = '0;

  // One clock cycle: drive inputs, settle, then score any accepted command.
  task automatic cycle(input logic rdy, input logic jmp, input logic [7:0] tgt,
                       input logic rst);
    @(negedge clock);
    memLat          = latReq;
    bus.cmd_ready   = rdy;
    bus.jump_en     = jmp;
    bus.jump_target = tgt;
    reset           = rst;
    #2;
    if (sbOn && bus.cmd_valid === 1'b1 && rdy) begin
      check("sb_cmd_addr", bus.cmd_addr, expAddr);
      check("sb_cmd_out", bus.cmd_out, prog[expAddr]);
      expAddr++;
    end
  endtask

  task automatic expectFetch(input string tag, input logic req, input logic [7:0] addr);
    check({tag, "_mem_req"}, bus.mem_req, req);
    if (req) check({tag, "_mem_addr"}, bus.mem_addr, addr);
  endtask

  task automatic expectCmd(input string tag, input logic vld, input logic [7:0] addr);
    check({tag, "_cmd_valid"}, bus.cmd_valid, vld);
    if (vld) check({tag, "_cmd_addr"}, bus.cmd_addr, addr);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) prog[i] = {16'h0400, 8'(i)};
    reset             = 1'b1;
    bus.cmd_ready     = 1'b1;
    bus.jump_en       = 1'b0;
    bus.jump_target   = '0;
    feBus.cmd_ready   = 1'b1;
    feBus.jump_en     = 1'b0;
    feBus.jump_target = '0;

    // Reset state
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_cmd_valid", bus.cmd_valid, 0);
    check("rst_cmd_out", bus.cmd_out, 0);
    check("rst_cmd_addr", bus.cmd_addr, 0);
    check("rst_halted", bus.halted, 0);

    // Streaming with 1-cycle memory (cycles 0..5); wrap-around on the FE instance
    sbOn = 1'b1;
    expAddr = 8'h00;
    for (int k = 0; k < 6; k++) begin
      logic [7:0] feA;
      cycle(1, 0, 0, 0);
      expectFetch("stream", 1'b1, 8'(k));
      expectCmd("stream", k >= 2, 8'(k - 2));
      feA = 8'hFE + 8'(k);
      check("fe_mem_addr", feBus.mem_addr, feA);
      if (k >= 2) begin
        feA = 8'hFE + 8'(k - 2);
        check("fe_cmd_addr", feBus.cmd_addr, feA);
        check("fe_cmd_out", feBus.cmd_out, {16'h0400, feA});
      end
    end

    // Decoder stall for 6 cycles (cycles 6..11): buffer fills, fetch stops
    for (int k = 0; k < 6; k++) begin
      cycle(0, 0, 0, 0);
      check("stall_mem_req", bus.mem_req, 0);
      expectCmd("stall", 1'b1, 8'h04);
      check("stall_cmd_out", bus.cmd_out, 24'h040004);
    end
    // Resume (cycles 12..14)
    cycle(1, 0, 0, 0); expectCmd("resume0", 1'b1, 8'h04); expectFetch("resume0", 1'b1, 8'h06);
    cycle(1, 0, 0, 0); expectCmd("resume1", 1'b1, 8'h05); expectFetch("resume1", 1'b1, 8'h07);
    cycle(1, 0, 0, 0); expectCmd("resume2", 1'b1, 8'h06); expectFetch("resume2", 1'b1, 8'h08);

    // 3-cycle memory; jump to 0x05 (cycle 15), then to 0x40 while 0x05 is in flight
    latReq = 3;
    cycle(1, 1, 8'h05, 0);
    check("jmp1_mem_req", bus.mem_req, 0);
    expAddr = 8'h05;
    cycle(1, 0, 0, 0);                       // 16
    expectFetch("jmp1_next", 1'b1, 8'h05);
    check("jmp1_next_cmd_valid", bus.cmd_valid, 0);
    cycle(1, 1, 8'h40, 0);                   // 17
    check("jmp2_mem_req", bus.mem_req, 0);
    expAddr = 8'h40;
    for (int k = 18; k <= 23; k++) begin
      cycle(1, 0, 0, 0);
      check("discard_cmd_valid", bus.cmd_valid, 0);
      if (k == 20)      expectFetch("redirect", 1'b1, 8'h40);
      else if (k == 23) expectFetch("redirect_next", 1'b1, 8'h41);
      else              check("discard_mem_req", bus.mem_req, 0);
    end
    cycle(1, 0, 0, 0);                       // 24
    expectCmd("first_after_jump", 1'b1, 8'h40);
    check("first_after_jump_out", bus.cmd_out, 24'h040040);
    cycle(1, 0, 0, 0);                       // 25

    // HALT at 0x03 with 1-cycle memory; jump at 26 drops 0x41 in the same cycle
    prog[3] = 24'hFC0000;
    latReq = 1;
    cycle(1, 1, 8'h00, 0);                   // 26
    expAddr = 8'h00;
    for (int k = 0; k < 9; k++) begin        // 27..35
      cycle(1, 0, 0, 0);
      expectFetch("halt", k <= 3, 8'(k));
      expectCmd("halt", k >= 2 && k <= 5, 8'(k - 2));
      if (k == 5) check("halt_word", bus.cmd_out, 24'hFC0000);
      check("halt_halted", bus.halted, k >= 6);
    end
    prog[3] = 24'h040003;

    // Jump out of HALTED; then reset with a request outstanding
    latReq = 3;
    cycle(1, 1, 8'h10, 0);                   // 36
    check("unhalt_jump_halted", bus.halted, 1);
    expAddr = 8'h10;
    cycle(1, 0, 0, 0);                       // 37
    check("unhalt_halted", bus.halted, 0);
    expectFetch("unhalt", 1'b1, 8'h10);
    cycle(1, 0, 0, 1);                       // 38
    check("reset_cyc_mem_req", bus.mem_req, 0);
    expAddr = 8'h00;
    cycle(1, 0, 0, 0);                       // 39: late response arrives now
    check("mid_rst_cmd_valid", bus.cmd_valid, 0);
    check("mid_rst_cmd_out", bus.cmd_out, 0);
    check("mid_rst_cmd_addr", bus.cmd_addr, 0);
    check("mid_rst_halted", bus.halted, 0);
    expectFetch("mid_rst", 1'b1, 8'h00);
    check("mid_rst_fe_mem_addr", feBus.mem_addr, 8'hFE);
    for (int k = 40; k <= 42; k++) begin
      cycle(1, 0, 0, 0);
      check("ghost_cmd_valid", bus.cmd_valid, 0);
      expectFetch("post_rst", k == 42, 8'h01);
    end
    cycle(1, 0, 0, 0);                       // 43
    expectCmd("post_rst", 1'b1, 8'h00);
    check("post_rst_out", bus.cmd_out, 24'h040000);
    for (int k = 0; k < 6; k++) cycle(1, 0, 0, 0);

    check("one_outstanding", protoErr, 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Front-end stage that walks the 8-bit instruction pointer through program memory, fetches 24-bit command words and presents them, with their addresses, to the command decoder over a valid/ready handshake. Sits directly upstream of the control matrix: its `cmd_out` drives the decoder's command input. A small prefetch buffer decouples memory latency from decoder stalls. Jumps requested by the decoder flush the buffer and redirect fetch.

## Interface
- `ADDR_W`, 8: instruction pointer / program memory address width.
- `INSTR_W`, 24: command word width ([23:18] opcode, [17:9] operand 1, [8:0] operand 2).
- `DEPTH`, 2: prefetch buffer entries (power of two, ≥2).
- `RESET_PC`, 8'h00: first fetch address after reset.

- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mem_req`  out  1  one-cycle pulse: read `mem_addr`.
- `mem_addr`  out  ADDR_W  fetch address, valid when `mem_req`=1.
- `mem_rvalid`  in  1  one-cycle pulse, exactly one per request, ≥1 cycle after it.
- `mem_rdata`  in  INSTR_W  returned word, valid with `mem_rvalid`.
- `cmd_valid`  out  1  buffer head available.
- `cmd_ready`  in  1  decoder accepts head this cycle.
- `cmd_out`  out  INSTR_W  head command word.
- `cmd_addr`  out  ADDR_W  address the head was fetched from.
- `jump_en`  in  1  one-cycle redirect request.
- `jump_target`  in  ADDR_W  redirect address.
- `halted`  out  1  HALT consumed; fetch stopped.

## Operation
- States: RUN (issuing), STOPPING (HALT buffered, no new requests), HALTED. Reset → RUN.
- Reset (mid-operation included): `pc`=RESET_PC, buffer empty, outstanding=0, discard=0, `mem_req`=0, `cmd_valid`=0, `cmd_out`=0, `cmd_addr`=0, `halted`=0. A `mem_rvalid` arriving with outstanding=0 is ignored.
- At most one request outstanding. Issue in cycle t iff state=RUN, no `jump_en`, discard=0, (outstanding=0 or `mem_rvalid` this cycle), and occupancy after this cycle's push/pop < DEPTH. On issue: `mem_addr`=`pc`, `pc`←`pc`+1 mod 2^ADDR_W (8'hFF→8'h00).
- Response (not discarded): push {`pc` of request, `mem_rdata`}. If opcode = OPC_HALT (6'b111111): RUN→STOPPING; word still pushed and delivered.
- Handshake: pop when `cmd_valid`&&`cmd_ready`. `cmd_out`/`cmd_addr` stable while `cmd_valid`=1 and not accepted. Push and pop in the same cycle allowed when full.
- HALT popped: STOPPING→HALTED, `halted`=1 next cycle.
- Jump (priority over everything): head accepted in that cycle counts as consumed; all other entries dropped; `pc`←`jump_target`; state←RUN, `halted`←0. Outstanding request with no `mem_rvalid` that cycle → discard=1; next `mem_rvalid` dropped and clears discard. `mem_rvalid` in the jump cycle: dropped, no discard. No request in the jump cycle.

## Timing
- First `mem_req` in the first cycle with `reset`=0.
- `mem_rvalid` in cycle N → `cmd_valid`=1 in N+1 (registered buffer; no combinational rdata→cmd_out path).
- 1-cycle memory, decoder always ready: one command per cycle sustained.
- Jump in cycle J, no discard: `mem_req` at `jump_target` in J+1; `cmd_valid`=0 in J+1.
- `cmd_ready` does not combinationally affect `cmd_valid`/`cmd_out`; `mem_req` may depend combinationally on `mem_rvalid` and `cmd_ready`.

## Structure
- Package `fetch_pkg`: ADDR_W, INSTR_W, opcode field slice bounds, OPC_HALT, state enum {RUN, STOPPING, HALTED}.
- Sub-module `fetch_fifo`: DEPTH-entry {addr, instr} FIFO with push, pop, synchronous flush, count, full/empty. FSM, pc, outstanding/discard tracking in `instruction_fetch`.

## Test plan
- Reset, 1-cycle memory holding words 0x04xxxx at 0x00..0x03, `cmd_ready`=1 → `mem_addr` 0,1,2,3 on consecutive cycles; `cmd_addr` 0,1,2,3 one cycle after each `mem_rvalid`; one command per cycle.
- `cmd_ready`=0 for 6 cycles → exactly DEPTH=2 responses buffered, `mem_req` low once full, `cmd_out` stable; resume → no loss or duplication, in-order addresses.
- `RESET_PC`=8'hFE → fetch 0xFE, 0xFF, 0x00, 0x01.
- 3-cycle memory latency, `jump_en` with `jump_target`=0x40 while request to 0x05 outstanding → 0x05 response dropped, next `mem_req` at 0x40 only after it returns, first delivered `cmd_addr`=0x40.
- Word 0xFC0000 at 0x03 → no `mem_req` after its response, delivered at `cmd_addr` 0x03, `halted`=1 cycle after acceptance; `jump_en` to 0x10 → `halted`=0, fetch 0x10.
- `reset` asserted one cycle with request outstanding → all outputs at reset values; late `mem_rvalid` ignored; fetch restarts at `RESET_PC`.
